// File: rtl/fifo_128_32_pkg.sv
// fifo_128_32_pkg: widths, pointer types and occupancy helper for the 128x32 FWFT FIFO
package fifo_128_32_pkg;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 1 << AW;
  typedef logic [DW-1:0] word_t;
  typedef logic [AW:0] ptr_t;
  typedef logic [AW-1:0] addr_t;
  function automatic ptr_t occupancy(input ptr_t w, input ptr_t r);
    return w - r;
  endfunction
endpackage

// File: rtl/fifo_128_32_ram.sv
// ram_128_32: simple dual-port 128x32 RAM with a registered read port held while re is low
import fifo_128_32_pkg::*;
module ram_128_32 (
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t wa,
  input  word_t wd,
  input  logic  re,
  input  addr_t ra,
  output word_t rd
);
  word_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we && !rst) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/fifo_128_32.sv
// fifo_128_32: first-word-fall-through FIFO, 128 words in RAM plus the RAM read register as head stage
import fifo_128_32_pkg::*;
module fifo_128_32 #(
  parameter int AF_THRESH = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  level,
  output logic        almost_full
);
  ptr_t wptr, rptr, wptr_n, rptr_n, ram_cnt;
  logic hv, hv_n, push, pop, re;
  logic [7:0] level_n;
  assign ram_cnt = occupancy(wptr, rptr);
  assign s_ready = rst && !flush && (ram_cnt != ptr_t'(DEPTH));
  assign push = s_valid && s_ready;
  assign pop = hv && m_ready;
  // prefetch keeps the head register full whenever the RAM has a word to give
  assign re = !flush && (ram_cnt != '0) && (!hv || m_ready);
  assign m_valid = hv;
  always_comb begin
    wptr_n = flush ? '0 : wptr + ptr_t'(push);
    rptr_n = flush ? '0 : rptr + ptr_t'(re);
    hv_n = flush ? 1'b0 : re ? 1'b1 : pop ? 1'b0 : hv;
    level_n = occupancy(wptr_n, rptr_n) + 8'(hv_n);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      hv <= 1'b0;
      level <= '0;
      almost_full <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      hv <= hv_n;
      level <= level_n;
      almost_full <= level_n >= 8'(AF_THRESH);
    end
  ram_128_32 u_ram (
    .clk(clk),
    .rst(!rst),
    .we(push),
    .wa(wptr[AW-1:0]),
    .wd(s_data),
    .re(re),
    .ra(rptr[AW-1:0]),
    .rd(m_data)
  );
endmodule

// File: tb/tb_fifo_128_32.sv
// tb_fifo_128_32: directed checks of fill, drain, streaming, back-pressure, flush and async reset
module tb_fifo_128_32;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic [31:0] m_data;
  logic s_ready, m_valid, almost_full;
  logic [7:0] level;
  int tests = 0, failed = 0;
  logic [31:0] q [$];
  always #5 clk = ~clk;
  fifo_128_32 dut (
    .clk(clk), .rst(rst), .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level), .almost_full(almost_full)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rcycle(input int c);
    bit ps, pp;
    if (c >= 0) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = $urandom;
      m_ready = $urandom_range(0, 3) < (c < 1000 ? 1 : 3);
    end
    #1;
    if (m_valid) chk("rnd_head", m_data, q[0]);
    if (q.size() == 0) chk("rnd_empty_valid", 32'(m_valid), 0);
    if (q.size() >= 2) chk("rnd_nonempty_valid", 32'(m_valid), 1);
    if (q.size() < 128) chk("rnd_ready", 32'(s_ready), 1);
    if (q.size() == 129) chk("rnd_full_ready", 32'(s_ready), 0);
    ps = s_valid && s_ready;
    pp = m_valid && m_ready;
    if (pp) void'(q.pop_front());
    if (ps) q.push_back(s_data);
    step;
    chk("rnd_level", 32'(level), q.size());
  endtask
  initial begin
    int exp;
    step;
    step;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_af", 32'(almost_full), 0);
    rst = 1'b1;
    step;
    chk("post_rst_s_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    step;
    s_valid = 1'b0;
    chk("single_not_yet_valid", 32'(m_valid), 0);
    chk("single_level_a", 32'(level), 1);
    step;
    chk("single_valid", 32'(m_valid), 1);
    chk("single_data", m_data, 32'hDEADBEEF);
    chk("single_level_b", 32'(level), 1);
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    chk("single_popped_valid", 32'(m_valid), 0);
    chk("single_popped_level", 32'(level), 0);
    for (int i = 0; i <= 128; i++) begin
      s_data = i;
      s_valid = 1'b1;
      step;
      if (i == 118) chk("af_at_119", 32'(almost_full), 0);
      if (i == 119) chk("af_at_120", 32'(almost_full), 1);
    end
    chk("fill_level", 32'(level), 129);
    chk("fill_s_ready", 32'(s_ready), 0);
    chk("fill_af", 32'(almost_full), 1);
    s_data = 999;
    step;
    s_valid = 1'b0;
    chk("overfill_level", 32'(level), 129);
    m_ready = 1'b1;
    for (int i = 0; i <= 128; i++) begin
      chk("drain", {m_valid, m_data[30:0]}, {1'b1, i[30:0]});
      step;
    end
    chk("drain_end_valid", 32'(m_valid), 0);
    chk("drain_end_level", 32'(level), 0);
    exp = 0;
    for (int k = 0; k < 1000; k++) begin
      s_data = k;
      s_valid = 1'b1;
      step;
      if (k >= 1) begin
        chk("stream", {m_valid, m_data[30:0]}, {1'b1, exp[30:0]});
        exp++;
      end
      chk("stream_level", 32'(level <= 8'd2), 1);
    end
    s_valid = 1'b0;
    step;
    chk("stream_tail", {m_valid, m_data[30:0]}, {1'b1, 31'd999});
    step;
    m_ready = 1'b0;
    chk("stream_end_valid", 32'(m_valid), 0);
    chk("stream_end_level", 32'(level), 0);
    for (int c = 0; c < 2000; c++) rcycle(c);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 140; c++) rcycle(-1);
    m_ready = 1'b0;
    chk("rnd_drained", 32'(level), 0);
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_data = 100 + i;
      step;
    end
    s_valid = 1'b0;
    step;
    chk("pre_flush_level", 32'(level), 50);
    chk("pre_flush_valid", 32'(m_valid), 1);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h55;
    m_ready = 1'b1;
    #1;
    chk("flush_s_ready", 32'(s_ready), 0);
    step;
    flush = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_valid", 32'(m_valid), 0);
    s_valid = 1'b1;
    s_data = 32'hABC;
    step;
    s_valid = 1'b0;
    step;
    chk("post_flush_head", {m_valid, m_data[30:0]}, {1'b1, 31'hABC});
    chk("post_flush_level", 32'(level), 1);
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    chk("post_flush_empty", 32'(level), 0);
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 200 + i;
      step;
    end
    s_valid = 1'b0;
    step;
    chk("pre_reset_level", 32'(level), 10);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 0);
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_s_ready", 32'(s_ready), 0);
    chk("async_rst_af", 32'(almost_full), 0);
    step;
    rst = 1'b1;
    #1;
    chk("release_s_ready", 32'(s_ready), 1);
    chk("release_level", 32'(level), 0);
    s_valid = 1'b1;
    s_data = 32'h1;
    step;
    s_valid = 1'b0;
    step;
    chk("after_rst_head", {m_valid, m_data[30:0]}, {1'b1, 31'h1});
    chk("after_rst_level", 32'(level), 1);
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    chk("after_rst_only_valid", 32'(m_valid), 0);
    chk("after_rst_only_level", 32'(level), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
